// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed eight-digit scan driver with per-frame snapshot and anode blanking
//   clk, rst      : clock, asynchronous active-high reset
//   seg_in[63:0]  : segment bytes, digit i = seg_in[8i+7:8i]
//   en_in[7:0]    : per-digit enable
//   seg_data[7:0] : shared segment bus, active-high, 00 when blank
//   an[7:0]       : digit anodes, active-low
//   frame_start   : one-cycle pulse in the first cycle of slot 0
module seg_scan_driver #(
  parameter int SCAN_DIV = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] seg_in,
  input  logic [7:0]  en_in,
  output logic [7:0]  seg_data,
  output logic [7:0]  an,
  output logic        frame_start
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK = CW'(BLANK_CYCLES);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] d_q, d_d;
  logic [63:0] seg_f_q, seg_f_d;
  logic [7:0] en_f_q, en_f_d, an_d, seg_data_d;
  logic frame_start_d, wrap, show;
  // outputs decode the next state so they switch on the same edge as cnt/d
  always_comb begin
    wrap = cnt_q == LAST;
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    d_d = wrap ? d_q + 3'd1 : d_q;
    seg_f_d = (wrap && d_q == 3'd7) ? seg_in : seg_f_q;
    en_f_d = (wrap && d_q == 3'd7) ? en_in : en_f_q;
    show = cnt_d >= BLANK && en_f_d[d_d];
    an_d = show ? ~(8'd1 << d_d) : 8'hFF;
    seg_data_d = show ? seg_f_d[{d_d, 3'b000} +: 8] : 8'h00;
    frame_start_d = cnt_d == '0 && d_d == 3'd0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= LAST;
      d_q <= 3'd7;
      seg_f_q <= '0;
      en_f_q <= '0;
      an <= 8'hFF;
      seg_data <= 8'h00;
      frame_start <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      d_q <= d_d;
      seg_f_q <= seg_f_d;
      en_f_q <= en_f_d;
      an <= an_d;
      seg_data <= seg_data_d;
      frame_start <= frame_start_d;
    end
  end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: randomized self-checking bench for seg_scan_driver against a cycle-time reference model
module tb_seg_scan_driver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [63:0] seg_in;
  logic [7:0] en_in;
  logic [7:0] seg_a, an_a, seg_b, an_b;
  logic fs_a, fs_b;
  int t;
  logic [63:0] sa_seg, sb_seg;
  logic [7:0] sa_en, sb_en;
  logic [16:0] ea, eb;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seg_scan_driver #(.SCAN_DIV(8), .BLANK_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .seg_in(seg_in), .en_in(en_in),
    .seg_data(seg_a), .an(an_a), .frame_start(fs_a)
  );
  seg_scan_driver #(.SCAN_DIV(2), .BLANK_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .seg_in(seg_in), .en_in(en_in),
    .seg_data(seg_b), .an(an_b), .frame_start(fs_b)
  );

  // t = edges since reset release; a frame is 8*SCAN_DIV edges, snapshot at each frame's first edge
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      t <= 0;
      sa_seg <= '0; sa_en <= '0; sb_seg <= '0; sb_en <= '0;
    end else begin
      t <= t + 1;
      if (t % 64 == 0) begin sa_seg <= seg_in; sa_en <= en_in; end
      if (t % 16 == 0) begin sb_seg <= seg_in; sb_en <= en_in; end
    end
  end

  // expected {an, seg_data, frame_start} in cycle k after release
  function automatic logic [16:0] exp_out(int sd, int bl, int k, logic [63:0] s, logic [7:0] e);
    int pos, slot;
    logic [7:0] onehot;
    if (k == 0) return {8'hFF, 8'h00, 1'b0};
    pos = (k - 1) % sd;
    slot = ((k - 1) / sd) % 8;
    onehot = 8'h01 << slot;
    if (pos >= bl && e[slot]) return {~onehot, s[slot*8 +: 8], 1'b0};
    return {8'hFF, 8'h00, (pos == 0 && slot == 0)};
  endfunction

  always @(negedge clk) begin
    vectors += 2;
    if ($countones(~an_a) > 1) begin
      miscompares++;
      $display("FAIL onehot_a: an=%h has more than one low bit", an_a);
    end
    if ($countones(~an_b) > 1) begin
      miscompares++;
      $display("FAIL onehot_b: an=%h has more than one low bit", an_b);
    end
  end

  task automatic restart();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_reset();
    seg_in = {$urandom, $urandom};
    en_in = 8'($urandom);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors += 2;
    if ({an_a, seg_a, fs_a} !== {8'hFF, 8'h00, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_a: got %h want %h", {an_a, seg_a, fs_a}, {8'hFF, 8'h00, 1'b0});
    end
    if ({an_b, seg_b, fs_b} !== {8'hFF, 8'h00, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_b: got %h want %h", {an_b, seg_b, fs_b}, {8'hFF, 8'h00, 1'b0});
    end
  endtask

  task automatic test_scan(input logic [7:0] en, input string name);
    for (int i = 0; i < 8; i++) seg_in[i*8 +: 8] = 8'h10 + 8'(i);
    en_in = en;
    restart();
    repeat (140) begin
      @(negedge clk);
      ea = exp_out(8, 2, t, sa_seg, sa_en);
      eb = exp_out(2, 1, t, sb_seg, sb_en);
      vectors += 2;
      if ({an_a, seg_a, fs_a} !== ea) begin
        miscompares++;
        $display("FAIL %s_a cycle %0d: got %h want %h", name, t, {an_a, seg_a, fs_a}, ea);
      end
      if ({an_b, seg_b, fs_b} !== eb) begin
        miscompares++;
        $display("FAIL %s_b cycle %0d: got %h want %h", name, t, {an_b, seg_b, fs_b}, eb);
      end
      if (t == 65 || t == 129) begin
        vectors++;
        if (fs_a !== 1'b1) begin
          miscompares++;
          $display("FAIL %s_frame_period cycle %0d: got fs=%b want 1", name, t, fs_a);
        end
      end
    end
  endtask

  task automatic test_tearing();
    for (int i = 0; i < 8; i++) seg_in[i*8 +: 8] = 8'h10 + 8'(i);
    en_in = 8'hFF;
    restart();
    repeat (140) begin
      @(negedge clk);
      ea = exp_out(8, 2, t, sa_seg, sa_en);
      eb = exp_out(2, 1, t, sb_seg, sb_en);
      vectors += 2;
      if ({an_a, seg_a, fs_a} !== ea) begin
        miscompares++;
        $display("FAIL tearing_a cycle %0d: got %h want %h", t, {an_a, seg_a, fs_a}, ea);
      end
      if ({an_b, seg_b, fs_b} !== eb) begin
        miscompares++;
        $display("FAIL tearing_b cycle %0d: got %h want %h", t, {an_b, seg_b, fs_b}, eb);
      end
      if (t == 59) begin
        vectors++;
        if ({an_a, seg_a} !== {8'h7F, 8'h17}) begin
          miscompares++;
          $display("FAIL tearing_old_frame: got %h want 7f17", {an_a, seg_a});
        end
      end
      if (t == 67) begin
        vectors++;
        if ({an_a, seg_a} !== {8'hFE, 8'hAA}) begin
          miscompares++;
          $display("FAIL tearing_new_frame: got %h want feaa", {an_a, seg_a});
        end
      end
      if (t == 20) seg_in = {8{8'hAA}};
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 8; i++) seg_in[i*8 +: 8] = 8'h10 + 8'(i);
    en_in = 8'hFF;
    restart();
    while (t < 28) @(negedge clk);
    vectors++;
    if (an_a !== 8'hF7) begin
      miscompares++;
      $display("FAIL async_pre: got an=%h want f7", an_a);
    end
    #2 rst = 1'b1;
    #1;
    vectors += 2;
    if ({an_a, seg_a, fs_a} !== {8'hFF, 8'h00, 1'b0}) begin
      miscompares++;
      $display("FAIL async_a: got %h want %h", {an_a, seg_a, fs_a}, {8'hFF, 8'h00, 1'b0});
    end
    if ({an_b, seg_b, fs_b} !== {8'hFF, 8'h00, 1'b0}) begin
      miscompares++;
      $display("FAIL async_b: got %h want %h", {an_b, seg_b, fs_b}, {8'hFF, 8'h00, 1'b0});
    end
    seg_in = {$urandom, $urandom};
    en_in = 8'($urandom) | 8'h01;
    @(negedge clk) rst = 1'b0;
    repeat (70) begin
      @(negedge clk);
      ea = exp_out(8, 2, t, sa_seg, sa_en);
      eb = exp_out(2, 1, t, sb_seg, sb_en);
      vectors += 2;
      if ({an_a, seg_a, fs_a} !== ea) begin
        miscompares++;
        $display("FAIL async_post_a cycle %0d: got %h want %h", t, {an_a, seg_a, fs_a}, ea);
      end
      if ({an_b, seg_b, fs_b} !== eb) begin
        miscompares++;
        $display("FAIL async_post_b cycle %0d: got %h want %h", t, {an_b, seg_b, fs_b}, eb);
      end
    end
  endtask

  task automatic test_random();
    seg_in = {$urandom, $urandom};
    en_in = 8'($urandom);
    restart();
    repeat (400) begin
      @(negedge clk);
      ea = exp_out(8, 2, t, sa_seg, sa_en);
      eb = exp_out(2, 1, t, sb_seg, sb_en);
      vectors += 2;
      if ({an_a, seg_a, fs_a} !== ea) begin
        miscompares++;
        $display("FAIL random_a cycle %0d: got %h want %h", t, {an_a, seg_a, fs_a}, ea);
      end
      if ({an_b, seg_b, fs_b} !== eb) begin
        miscompares++;
        $display("FAIL random_b cycle %0d: got %h want %h", t, {an_b, seg_b, fs_b}, eb);
      end
      if ($urandom_range(3) == 0) begin
        seg_in = {$urandom, $urandom};
        en_in = 8'($urandom);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan(8'hFF, "scan");
    test_tearing();
    test_scan(8'b1010_1010, "enable");
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexing scan driver that sits directly downstream of the eight-tube pattern generator. It takes the generator's eight decoded segment bytes (seg_in, 64 bits) and per-tube enables (en_in, 8 bits) and drives one physical digit at a time through a shared segment bus and active-low digit anodes. Each frame starts with a full 72-bit snapshot so mid-frame input changes cannot tear the display. Anodes are blanked for a short guard interval at every digit change to suppress ghosting.

## Interface
- SCAN_DIV, 100000, clock cycles per digit slot (1 ms at 100 MHz); legal range 2..2^24
- BLANK_CYCLES, 16, guard cycles at the start of each slot with all anodes off; legal range 1..SCAN_DIV-1
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  asynchronous, active-high reset
- seg_in  input  64  segment bytes; digit i = seg_in[8i+7:8i], active-high segments
- en_in  input  8  per-digit enable; en_in[i]=1 means digit i is lit
- seg_data  output  8  shared segment bus, active-high; 8'h00 when blank
- an  output  8  digit anodes, active-low, one-hot-zero or all-ones
- frame_start  output  1  one-cycle pulse in the first cycle of slot 0

## Operation
- State: slot counter cnt (0..SCAN_DIV-1, width $clog2(SCAN_DIV)), digit index d (3 bits), frame registers seg_f[63:0] and en_f[7:0].
- Reset state: cnt=SCAN_DIV-1, d=7, seg_f=0, en_f=0. The first edge after release wraps into slot 0.
- Every edge: if cnt==SCAN_DIV-1, cnt<=0 and d<=d+1 (7 wraps to 0); otherwise cnt<=cnt+1.
- Snapshot: on the edge that moves d from 7 to 0, seg_f<=seg_in and en_f<=en_in. No other edge loads them.
- Per-cycle output for the current (cnt,d):
  - Blank phase, cnt<BLANK_CYCLES: an=8'hFF, seg_data=8'h00.
  - Show phase, cnt>=BLANK_CYCLES and en_f[d]=1: an[d]=0, other bits 1; seg_data=seg_f[8d+7:8d].
  - Show phase, en_f[d]=0: an=8'hFF, seg_data=8'h00. The slot keeps its full length, so brightness of lit digits is independent of the enable pattern.
- frame_start=1 exactly when cnt==0 and d==0.
- Outputs are registers. Next-state values are decoded so an, seg_data and frame_start change on the same edge as cnt and d, with no combinational path to the pins.

## Timing
- Reset (async): an=8'hFF, seg_data=8'h00, frame_start=0 immediately, without waiting for a clock. Counters and frame registers take their reset values.
- Reset mid-operation aborts the current frame. Previous frame contents are discarded.
- First edge after release: frame_start=1 and the snapshot is taken in the same cycle. Output is blank for BLANK_CYCLES cycles. Digit 0 shows from cycle BLANK_CYCLES to SCAN_DIV-1.
- Slot length is SCAN_DIV cycles. Frame period is 8*SCAN_DIV cycles. frame_start repeats exactly every 8*SCAN_DIV cycles.
- Input-to-display latency: a change to seg_in/en_in appears at the next frame_start, at most 8*SCAN_DIV cycles later. Changes in any other cycle are ignored until then.
- At no edge may two anode bits be low at once. A digit change always passes through at least BLANK_CYCLES all-off cycles.

## Test plan
- SCAN_DIV=8, BLANK_CYCLES=2, seg_in byte i=8'h10+i, en_in=8'hFF, release reset:
  - Cycle 1: frame_start=1, an=FF for 2 cycles, then an=FE with seg_data=10 for 6 cycles.
  - Then an=FF for 2 cycles, then an=FD with seg_data=11, continuing through an=7F with seg_data=17.
  - frame_start again at cycle 65.
- Tearing: same setup, change seg_in to all 8'hAA at cycle 20 -> slots 2..7 still show 12..17; 8'hAA appears only from cycle 67 (slot 0 show phase of frame 2).
- en_in=8'b1010_1010 -> slots 0,2,4,6 give an=FF, seg_data=00 for all 8 cycles; slots 1,3,5,7 match scenario 1; frame_start period still 64.
- Async reset while an=F7 (slot 3 show phase), asserted between edges -> an=FF, seg_data=00, frame_start=0 immediately; after release the first edge gives frame_start=1 with a fresh snapshot.
- SCAN_DIV=2, BLANK_CYCLES=1 -> an alternates FF / active digit every cycle, d advances every 2 cycles, frame_start every 16 cycles.
- Throughout all runs, an assertion checks that popcount(~an)<=1 on every cycle.
